// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: FSM state encoding and address constants.
// Imported by router_fsm, router_reg and the synchronizer so that everyone
// agrees on the state codes and the address field width.
package router_pkg;

  // Number of destination FIFOs. Header addresses 0..NUM_DEST-1 are routable.
  localparam int NUM_DEST = 3;

  // Width of the header address field, carried in data_in[1:0].
  localparam int ADDR_W = 2;

  // Reserved header address. A header carrying it is dropped.
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  // Controller states. DECODE_ADDRESS is code 0 so that a cleared register
  // is idle. All eight codes are in use.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Purpose : control FSM of the 1x3 router; decodes the header address and
//           sequences header, payload and parity loading into router_reg.
// Latency : Moore machine, outputs decode the state register only (no
//           registered outputs); header in DA, first byte loaded one cycle later.
// Backpr. : fifo_full stalls in FIFO_FULL_STATE; a non-empty destination parks
//           the packet in WAIT_TILL_EMPTY; busy tells the source to hold its byte.
//
// Ports:
//   clock            system clock, rising edge
//   resetn           asynchronous active-low reset
//   pkt_valid        source strobe for header/payload; low on the parity byte
//   data_in          header address field, sampled in DECODE_ADDRESS
//   fifo_full        selected destination FIFO is full
//   fifo_empty       per-destination empty flags
//   soft_reset       per-destination timeout soft reset
//   parity_done      parity byte has been captured by router_reg
//   low_packet_valid pkt_valid fell while the FSM was stalled on full
//   detect_add .. rst_int_reg  one-hot state strobes for router_reg
//   write_enb_reg    write enable towards the synchronizer/FIFO path
//   busy             source must hold the current byte
module router_fsm #(
  parameter int NUM_DEST = router_pkg::NUM_DEST
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        pkt_valid,
  input  logic [router_pkg::ADDR_W-1:0] data_in,
  input  logic                        fifo_full,
  input  logic [NUM_DEST-1:0]         fifo_empty,
  input  logic [NUM_DEST-1:0]         soft_reset,
  input  logic                        parity_done,
  input  logic                        low_packet_valid,
  output logic                        detect_add,
  output logic                        lfd_state,
  output logic                        ld_state,
  output logic                        laf_state,
  output logic                        full_state,
  output logic                        rst_int_reg,
  output logic                        write_enb_reg,
  output logic                        busy
);

  import router_pkg::*;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;

  // Per-address lookups. din_* look at the incoming header byte (used only
  // while decoding); sel_* look at the latched destination.
  logic                din_ok;
  logic                din_empty;
  logic                sel_empty;
  logic                sel_soft;

  // Address selection is written as a compare loop rather than a direct
  // index so that an address at or beyond NUM_DEST reads as "not present"
  // instead of indexing past the end of the flag vectors.
  always_comb begin
    din_ok    = 1'b0;
    din_empty = 1'b0;
    sel_empty = 1'b0;
    sel_soft  = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (data_in == ADDR_W'(i)) begin
        din_ok    = 1'b1;
        din_empty = fifo_empty[i];
      end
      if (addr_q == ADDR_W'(i)) begin
        sel_empty = fifo_empty[i];
        sel_soft  = soft_reset[i];
      end
    end
    // The reserved code is never routable, whatever NUM_DEST is set to.
    if (data_in == INVALID_ADDR) begin
      din_ok    = 1'b0;
      din_empty = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
    end else begin
      state_q <= state_d;
    end
  end

  // Destination latch. It follows data_in for as long as the FSM sits in
  // DA with pkt_valid high, so when DA is left it holds the header that
  // caused the exit. Dropped (invalid) headers may leave it at 3; that is
  // harmless because DA never consults it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else if (state_q == DECODE_ADDRESS && pkt_valid) begin
      addr_q <= data_in;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;

    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
        // Invalid address or idle bus: the byte is simply dropped.
        if (pkt_valid && din_ok) begin
          state_d = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end

      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        state_d   = LOAD_DATA;
      end

      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
        // A full FIFO must be serviced before the parity byte is accepted,
        // so fifo_full wins even when pkt_valid has already dropped.
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end

      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        state_d       = CHECK_PARITY_ERROR;
      end

      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        state_d     = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end

      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end

      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        // Resume where the stall interrupted: packet already finished,
        // parity still to load, or more payload to come.
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_packet_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end

      WAIT_TILL_EMPTY: begin
        if (sel_empty) begin
          state_d = LOAD_FIRST_DATA;
        end
      end

      default: begin
        detect_add = 1'b1;
        busy       = 1'b0;
        state_d    = DECODE_ADDRESS;
      end
    endcase

    // A destination timeout abandons the packet from anywhere but idle.
    if (state_q != DECODE_ADDRESS && sel_soft) begin
      state_d = DECODE_ADDRESS;
    end
  end

endmodule
